// File: rtl/di_int_pkg.sv
`default_nettype none
// ============================================================================
// Module      : di_int_pkg
// Description : Register map, edge-type encodings and reset defaults shared
//               by the digital-input interrupt controller and its users.
// Revision    : 1.0 - initial release
// ============================================================================
package di_int_pkg;

   // Register addresses
   localparam logic [7:0] ADDR_CTRL     = 8'h00;
   localparam logic [7:0] ADDR_MASK     = 8'h01;
   localparam logic [7:0] ADDR_PEND     = 8'h02;
   localparam logic [7:0] ADDR_LEVEL    = 8'h03;
   localparam logic [7:0] ADDR_CFG_BASE = 8'h10;

   // Channel edge-type encodings
   localparam logic [1:0] TYPE_OFF  = 2'b00;
   localparam logic [1:0] TYPE_RISE = 2'b01;
   localparam logic [1:0] TYPE_FALL = 2'b10;
   localparam logic [1:0] TYPE_BOTH = 2'b11;

   // Filter length every channel starts with
   localparam logic [7:0] FMS_DEFAULT = 8'd10;

endpackage
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Free-running millisecond tick. Emits a one-cycle pulse on
//               the last count of every CLK_PER_MS-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
   parameter int U_DLY      = 1,
   parameter int CLK_PER_MS = 50000
)(
   input  logic clk,
   input  logic rst_n,
   output logic ms_pulse
);

   localparam int                c_CW   = $clog2(CLK_PER_MS);
   localparam logic [c_CW-1:0]   c_LAST = c_CW'(CLK_PER_MS - 1);

   // A period shorter than two cycles cannot produce a distinct pulse
   if (CLK_PER_MS < 2 || U_DLY < 0) begin : g_bad_param
      $error("ms_tick_gen: CLK_PER_MS must be >= 2 and U_DLY >= 0");
   end

   logic [c_CW-1:0] r_cnt;

   // Count 0..CLK_PER_MS-1 and wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

   // Pulse is decoded straight from the counter so it lines up with the wrap
   assign ms_pulse = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/di_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : di_int_ctrl
// Description : Configuration and interrupt aggregation for a bank of
//               digital-input edge-check channels: ms tick, per-channel
//               type/filter registers, pending latches and a masked irq,
//               all reachable through a simple strobe/ack register bus.
// Revision    : 1.0 - initial release
// ============================================================================
module di_int_ctrl
   import di_int_pkg::*;
#(
   parameter int U_DLY      = 1,
   parameter int CH_NUM     = 8,
   parameter int CLK_PER_MS = 50000
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CH_NUM-1:0]     sfo_in,
   input  logic [CH_NUM-1:0]     into_in,
   output logic                  ms_pulse,
   output logic [2*CH_NUM-1:0]   ch_type,
   output logic [8*CH_NUM-1:0]   ch_fms,
   input  logic                  bus_cs,
   input  logic                  bus_we,
   input  logic [7:0]            bus_addr,
   input  logic [15:0]           bus_wdata,
   output logic [15:0]           bus_rdata,
   output logic                  bus_ack,
   output logic                  irq
);

   if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
      $error("di_int_ctrl: CH_NUM must be in 1..16");
   end

   logic                  w_wr;
   logic                  w_rd;
   logic [CH_NUM-1:0]     w_cfg_sel;
   logic [CH_NUM-1:0]     w_pend_set;
   logic [CH_NUM-1:0]     w_pend_clr;
   logic [15:0]           w_rdata;
   logic                  w_unused_wdata;

   logic                  r_glb_en;
   logic [CH_NUM-1:0]     r_mask;
   logic [CH_NUM-1:0]     r_pend;
   logic [2*CH_NUM-1:0]   r_ch_type;
   logic [8*CH_NUM-1:0]   r_ch_fms;
   logic [15:0]           r_rdata;
   logic                  r_ack;
   logic                  r_irq;

   ms_tick_gen #(
      .U_DLY      (U_DLY),
      .CLK_PER_MS (CLK_PER_MS)
   ) u_ms_tick_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .ms_pulse (ms_pulse)
   );

   assign w_wr = bus_cs &  bus_we;
   assign w_rd = bus_cs & ~bus_we;

   // Top write-data bits carry no register field for small channel counts
   assign w_unused_wdata = ^bus_wdata[15:10];

   for (genvar n = 0; n < CH_NUM; n++) begin : g_cfg_sel
      assign w_cfg_sel[n] = (bus_addr == ADDR_CFG_BASE + 8'(n));
   end

   // New edges only count while globally enabled; set beats a same-cycle clear
   assign w_pend_set = into_in & {CH_NUM{r_glb_en}};
   assign w_pend_clr = (w_wr && bus_addr == ADDR_PEND) ? bus_wdata[CH_NUM-1:0] : '0;

   // Read-data mux; anything unmapped reads as zero
   always_comb begin
      w_rdata = '0;
      case (bus_addr)
         ADDR_CTRL  : w_rdata = {15'd0, r_glb_en};
         ADDR_MASK  : w_rdata = 16'(r_mask);
         ADDR_PEND  : w_rdata = 16'(r_pend);
         ADDR_LEVEL : w_rdata = 16'(sfo_in);
         default    : begin
            for (int n = 0; n < CH_NUM; n++) begin
               if (w_cfg_sel[n]) begin
                  w_rdata = {6'd0, r_ch_type[2*n +: 2], r_ch_fms[8*n +: 8]};
               end
            end
         end
      endcase
   end

   // Control, mask and pending registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_glb_en <= 1'b0;
         r_mask   <= '0;
         r_pend   <= '0;
      end else begin
         if (w_wr && bus_addr == ADDR_CTRL) begin
            r_glb_en <= bus_wdata[0];
         end
         if (w_wr && bus_addr == ADDR_MASK) begin
            r_mask <= bus_wdata[CH_NUM-1:0];
         end
         r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
      end
   end

   // Per-channel configuration; takes effect immediately, even mid-filter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch_type <= {CH_NUM{TYPE_OFF}};
         r_ch_fms  <= {CH_NUM{FMS_DEFAULT}};
      end else begin
         for (int n = 0; n < CH_NUM; n++) begin
            if (w_wr && w_cfg_sel[n]) begin
               r_ch_type[2*n +: 2] <= bus_wdata[9:8];
               r_ch_fms[8*n +: 8]  <= bus_wdata[7:0];
            end
         end
      end
   end

   // Bus response: one-cycle ack for every strobe, data only for reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ack   <= bus_cs;
         r_rdata <= w_rd ? w_rdata : 16'd0;
      end
   end

   // Registered, masked, globally gated interrupt level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= (|(r_pend & r_mask)) & r_glb_en;
      end
   end

   assign ch_type   = r_ch_type;
   assign ch_fms    = r_ch_fms;
   assign bus_rdata = r_rdata;
   assign bus_ack   = r_ack;
   assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_di_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_di_int_ctrl
// Description : Self-checking bench for di_int_ctrl: directed scenarios
//               followed by random traffic against a register-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_di_int_ctrl;
   import di_int_pkg::*;

   localparam int CH = 8;
   localparam int MS = 5;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic [CH-1:0]     sfo_in    = '0;
   logic [CH-1:0]     into_in   = '0;
   logic              bus_cs    = 1'b0;
   logic              bus_we    = 1'b0;
   logic [7:0]        bus_addr  = '0;
   logic [15:0]       bus_wdata = '0;
   wire               ms_pulse;
   wire [2*CH-1:0]    ch_type;
   wire [8*CH-1:0]    ch_fms;
   wire [15:0]        bus_rdata;
   wire               bus_ack;
   wire               irq;

   di_int_ctrl #(
      .U_DLY      (1),
      .CH_NUM     (CH),
      .CLK_PER_MS (MS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sfo_in    (sfo_in),
      .into_in   (into_in),
      .ms_pulse  (ms_pulse),
      .ch_type   (ch_type),
      .ch_fms    (ch_fms),
      .bus_cs    (bus_cs),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Register-level model of the controller
   bit            m_en;
   bit [CH-1:0]   m_mask;
   bit [CH-1:0]   m_pend;
   bit [1:0]      m_type [CH];
   bit [7:0]      m_fms  [CH];
   int            m_cyc;
   logic [15:0]   last_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_en   = 1'b0;
      m_mask = '0;
      m_pend = '0;
      for (int n = 0; n < CH; n++) begin
         m_type[n] = TYPE_OFF;
         m_fms[n]  = FMS_DEFAULT;
      end
      m_cyc = 0;
   endtask

   function automatic logic [15:0] m_read(input logic [7:0] a);
      int ai;
      ai = int'(a);
      if (ai == 0) return {15'd0, m_en};
      if (ai == 1) return 16'(m_mask);
      if (ai == 2) return 16'(m_pend);
      if (ai == 3) return 16'(sfo_in);
      if (ai >= 16 && ai < 16 + CH) return {6'd0, m_type[ai-16], m_fms[ai-16]};
      return 16'd0;
   endfunction

   function automatic logic [2*CH-1:0] exp_type();
      logic [2*CH-1:0] v;
      for (int n = 0; n < CH; n++) v[2*n +: 2] = m_type[n];
      return v;
   endfunction

   function automatic logic [8*CH-1:0] exp_fms();
      logic [8*CH-1:0] v;
      for (int n = 0; n < CH; n++) v[8*n +: 8] = m_fms[n];
      return v;
   endfunction

   // One clock with whatever inputs are currently driven, then check every output
   task automatic cycle();
      logic          e_ack;
      logic          e_irq;
      logic [15:0]   e_rd;
      logic [CH-1:0] clr;
      int            ai;
      e_ack = bus_cs;
      e_rd  = (bus_cs && !bus_we) ? m_read(bus_addr) : 16'd0;
      e_irq = ((m_pend & m_mask) != 0) && m_en;
      clr   = (bus_cs && bus_we && bus_addr == ADDR_PEND) ? bus_wdata[CH-1:0] : '0;
      m_pend = (m_pend & ~clr) | (m_en ? into_in : '0);
      if (bus_cs && bus_we) begin
         ai = int'(bus_addr);
         if (ai == 0) m_en = bus_wdata[0];
         if (ai == 1) m_mask = bus_wdata[CH-1:0];
         if (ai >= 16 && ai < 16 + CH) begin
            m_type[ai-16] = bus_wdata[9:8];
            m_fms[ai-16]  = bus_wdata[7:0];
         end
      end
      @(posedge clk);
      #1;
      m_cyc++;
      chk("ack",   bus_ack,   e_ack);
      chk("rdata", bus_rdata, e_rd);
      chk("irq",   irq,       e_irq);
      chk("tick",  ms_pulse,  (m_cyc % MS) == MS - 1);
      chk("type",  ch_type,   exp_type());
      chk("fms",   ch_fms,    exp_fms());
      last_rd = bus_rdata;
      bus_cs  = 1'b0;
      bus_we  = 1'b0;
      into_in = '0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      bus_cs = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      cycle();
      cycle();
   endtask

   task automatic rd(input logic [7:0] a, output logic [15:0] v);
      bus_cs = 1'b1; bus_we = 1'b0; bus_addr = a;
      cycle();
      v = last_rd;
      cycle();
   endtask

   task automatic pulse(input int ch);
      into_in = CH'(1) << ch;
      cycle();
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   logic [7:0] addr_tbl [15] = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12,
                                 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h7F};

   initial begin
      logic [15:0] v;
      int          np;

      // Reset state
      m_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irq",   irq,       1'b0);
      chk("rst_ack",   bus_ack,   1'b0);
      chk("rst_rdata", bus_rdata, 16'd0);
      chk("rst_tick",  ms_pulse,  1'b0);
      chk("rst_type",  ch_type,   16'd0);
      chk("rst_fms",   ch_fms,    {CH{8'h0A}});
      @(negedge clk);
      rst_n = 1'b1;
      m_cyc = 0;

      // Tick: pulses at cycles 4, 9, 14, 19 only
      np = 0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (ms_pulse) np++;
      end
      chk("tick_count", np, 4);

      // Config write/readback
      wr(8'h12, 16'h0123);
      chk("cfg_type2", ch_type[5:4],   2'b01);
      chk("cfg_fms2",  ch_fms[23:16],  8'h23);
      chk("cfg_fms0",  ch_fms[7:0],    8'h0A);
      chk("cfg_fms7",  ch_fms[63:56],  8'h0A);
      rd(8'h12, v);
      chk("cfg_rd", v, 16'h0123);

      // Interrupt path
      wr(ADDR_CTRL, 16'h0001);
      wr(ADDR_MASK, 16'h0005);
      pulse(2);
      cycle();
      chk("irq_set", irq, 1'b1);
      rd(ADDR_PEND, v);
      chk("pend_rd", v, 16'h0004);
      wr(ADDR_PEND, 16'h0004);
      chk("irq_clr", irq, 1'b0);

      // Masked channel latches but does not interrupt
      pulse(1);
      cycle();
      chk("irq_masked", irq, 1'b0);
      rd(ADDR_PEND, v);
      chk("pend_masked", v, 16'h0002);

      // Globally disabled: no new pending bits
      wr(ADDR_CTRL, 16'h0000);
      pulse(0);
      cycle();
      rd(ADDR_PEND, v);
      chk("pend_dis", v, 16'h0002);

      // Set and clear collide: set wins
      wr(ADDR_CTRL, 16'h0001);
      into_in = 8'h01;
      wr(ADDR_PEND, 16'h0001);
      rd(ADDR_PEND, v);
      chk("collide", v[0], 1'b1);

      // Unmapped address
      rd(8'h7F, v);
      chk("unmapped", v, 16'h0000);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         sfo_in  = CH'($urandom);
         into_in = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
         if ($urandom_range(0, 2) == 0) begin
            bus_cs    = 1'b1;
            bus_we    = 1'($urandom);
            bus_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : addr_tbl[$urandom_range(0, 14)];
            bus_wdata = 16'($urandom);
            cycle();
            sfo_in  = CH'($urandom);
            into_in = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
         end
         cycle();
      end

      // Asynchronous reset in the middle of an access while irq is high
      wr(ADDR_CTRL, 16'h0001);
      wr(ADDR_MASK, 16'h00FF);
      pulse(3);
      cycle();
      chk("irq_pre_rst", irq, 1'b1);
      bus_cs = 1'b1; bus_we = 1'b1; bus_addr = 8'h13; bus_wdata = 16'h03FF;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_irq",  irq,      1'b0);
      chk("arst_ack",  bus_ack,  1'b0);
      chk("arst_type", ch_type,  16'd0);
      chk("arst_fms",  ch_fms,   {CH{8'h0A}});
      chk("arst_tick", ms_pulse, 1'b0);
      bus_cs = 1'b0; bus_we = 1'b0;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("post_rst_ack", bus_ack, 1'b0);
      rd(ADDR_PEND, v);
      chk("post_rst_pend", v, 16'h0000);
      rd(8'h13, v);
      chk("post_rst_cfg", v, 16'h000A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
